// File: rtl/pc_unit_pkg.sv
// Shared definitions for the program-counter unit: next-PC op codes and
// a helper for sizing the return-address-stack occupancy counter.
package pc_unit_pkg;

    localparam int PC_OP_W = 3;

    // Next-PC operations; the two unused encodings fall back to sequential.
    typedef enum logic [PC_OP_W-1:0] {
        PC_OP_SEQ    = 3'd0,
        PC_OP_BRANCH = 3'd1,
        PC_OP_JUMP   = 3'd2,
        PC_OP_CALL   = 3'd3,
        PC_OP_RET    = 3'd4,
        PC_OP_TRAP   = 3'd5
    } pc_op_e;

    // Counter must represent 0..depth inclusive, hence one extra bit.
    function automatic int ras_count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/pc_unit_if.sv
// Fetch-side bundle of the PC unit: op request in, PC/link/status out.
interface pc_unit_if #(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 4
);
    import pc_unit_pkg::*;

    localparam int CNT_W = ras_count_width(RAS_DEPTH);

    logic               stall;
    logic [PC_OP_W-1:0] op;
    logic [XLEN-1:0]    target;
    logic [XLEN-1:0]    current_pc;
    logic [XLEN-1:0]    pc_plus_inc;
    logic               misaligned;
    logic               ras_overflow;
    logic               ras_underflow;
    logic [CNT_W-1:0]   ras_count;

    // Master issues the next-PC request and observes the unit's state.
    modport master (
        output stall, op, target,
        input  current_pc, pc_plus_inc, misaligned,
               ras_overflow, ras_underflow, ras_count
    );

    // Slave is the PC unit itself.
    modport slave (
        input  stall, op, target,
        output current_pc, pc_plus_inc, misaligned,
               ras_overflow, ras_underflow, ras_count
    );

endinterface

// File: rtl/pc_unit_ras.sv
// Circular return-address stack. When full, a push overwrites the oldest
// entry simply by letting the write pointer wrap; the count saturates.
module pc_unit_ras #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [XLEN-1:0]  push_data_i,
    output logic [XLEN-1:0]  top_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [XLEN-1:0]  mem_q [DEPTH];
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign top_o   = mem_q[ptr_q - PTR_W'(1)];
    assign count_o = count_q;

    // Pointer/count update; flush only clears occupancy, stale data is harmless.
    always_comb begin
        ptr_d   = ptr_q;
        count_d = count_q;
        if (flush_i) begin
            count_d = '0;
        end else if (push_i) begin
            ptr_d = ptr_q + PTR_W'(1);
            if (!full_o) begin
                count_d = count_q + CNT_W'(1);
            end
        end else if (pop_i && !empty_o) begin
            ptr_d   = ptr_q - PTR_W'(1);
            count_d = count_q - CNT_W'(1);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q   <= '0;
            count_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            count_q <= count_d;
        end
    end

    // Entry storage; contents are only meaningful below the count, so no reset.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) begin
            mem_q[ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit for the fetch stage: next-PC selection, alignment
// rejection, return-address stack and one-cycle status pulses.
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              INC          = 4,
    parameter int              RAS_DEPTH    = 4
) (
    input  logic     clk,
    input  logic     reset_n,
    pc_unit_if.slave bus
);

    localparam int              CNT_W      = ras_count_width(RAS_DEPTH);
    localparam logic [XLEN-1:0] INC_VAL    = XLEN'(INC);
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INC - 1);

    logic [XLEN-1:0]  pc_q, pc_d;
    logic             mis_q, mis_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic [XLEN-1:0]  cand;
    logic             chk, take;
    logic             ras_push, ras_pop, ras_flush;
    logic [XLEN-1:0]  ras_top;
    logic [CNT_W-1:0] ras_cnt;
    logic             ras_full, ras_empty;

    pc_unit_ras #(
        .XLEN  (XLEN),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk         (clk),
        .reset_n     (reset_n),
        .push_i      (ras_push),
        .pop_i       (ras_pop),
        .flush_i     (ras_flush),
        .push_data_i (bus.pc_plus_inc),
        .top_o       (ras_top),
        .count_o     (ras_cnt),
        .full_o      (ras_full),
        .empty_o     (ras_empty)
    );

    assign bus.current_pc    = pc_q;
    assign bus.pc_plus_inc   = pc_q + INC_VAL;
    assign bus.misaligned    = mis_q;
    assign bus.ras_overflow  = ovf_q;
    assign bus.ras_underflow = unf_q;
    assign bus.ras_count     = ras_cnt;

    // Choose the candidate PC (TRAP beats stall), then veto misaligned redirects.
    always_comb begin
        cand      = pc_q + INC_VAL;
        chk       = 1'b0;
        take      = 1'b1;
        ras_push  = 1'b0;
        ras_pop   = 1'b0;
        ras_flush = 1'b0;
        mis_d     = 1'b0;
        ovf_d     = 1'b0;
        unf_d     = 1'b0;
        if (bus.op == PC_OP_TRAP) begin
            cand      = bus.target;
            chk       = 1'b1;
            ras_flush = 1'b1;
        end else if (bus.stall) begin
            take = 1'b0;
        end else begin
            case (bus.op)
                PC_OP_BRANCH: begin
                    cand = pc_q + bus.target;
                    chk  = 1'b1;
                end
                PC_OP_JUMP: begin
                    cand = bus.target;
                    chk  = 1'b1;
                end
                PC_OP_CALL: begin
                    cand     = bus.target;
                    chk      = 1'b1;
                    ras_push = 1'b1;
                    ovf_d    = ras_full;
                end
                PC_OP_RET: begin
                    if (ras_empty) begin
                        unf_d = 1'b1;
                    end else begin
                        cand    = ras_top;
                        chk     = 1'b1;
                        ras_pop = 1'b1;
                    end
                end
                default: begin
                    cand = pc_q + INC_VAL;
                end
            endcase
        end
        if (take && chk && ((cand & ALIGN_MASK) != '0)) begin
            take      = 1'b0;
            ras_push  = 1'b0;
            ras_pop   = 1'b0;
            ras_flush = 1'b0;
            ovf_d     = 1'b0;
            mis_d     = 1'b1;
        end
        pc_d = take ? cand : pc_q;
    end

    // PC and status-pulse registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q  <= RESET_VECTOR;
            mis_q <= 1'b0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            mis_q <= mis_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

endmodule
